// File: rtl/flag_sequencer.sv
// Frame-synchronous pride-flag selector: dwell timer, debounced next/prev buttons,
// and a left-to-right wipe between the outgoing and incoming flag.
module flag_sequencer #(
    parameter int NUM_FLAGS       = 16,
    parameter int DWELL_FRAMES    = 300,
    parameter int WIPE_STEP       = 8,
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic [9:0] pix_x,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       auto_en,
    output logic [3:0] cur_flag,
    output logic [3:0] next_flag,
    output logic       sel_next,
    output logic       wipe_active
);

    localparam int DW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [3:0]    LAST_FLAG  = 4'(NUM_FLAGS - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_FRAMES - 1);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_FRAMES - 1);
    localparam logic [10:0]   STEP       = 11'(WIPE_STEP);

    typedef enum logic {SHOW, WIPE} state_t;

    logic [1:0] btn_raw;
    logic [1:0] press;     // bit 0 = next, bit 1 = prev; high for one frame per press

    assign btn_raw = {btn_prev, btn_next};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic [1:0]    sync_q, sync_d;
            logic          deb_q, deb_d;
            logic          last_q, last_d;
            logic [CW-1:0] cnt_q, cnt_d;

            assign sync_d = {sync_q[0], btn_raw[gi]};

            always_comb begin
                deb_d  = deb_q;
                last_d = last_q;
                cnt_d  = cnt_q;
                if (frame_start) begin
                    last_d = deb_q;
                    if (sync_q[1] != deb_q) begin
                        if (cnt_q == DEB_LAST) begin
                            deb_d = ~deb_q;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '0;
                    deb_q  <= 1'b0;
                    last_q <= 1'b0;
                    cnt_q  <= '0;
                end else begin
                    sync_q <= sync_d;
                    deb_q  <= deb_d;
                    last_q <= last_d;
                    cnt_q  <= cnt_d;
                end
            end

            // Debounced level rose at the previous frame_start; consumed at this one.
            assign press[gi] = deb_q & ~last_q;
        end
    endgenerate

    state_t        state_q, state_d;
    logic [3:0]    cur_q, cur_d;
    logic [3:0]    nxt_q, nxt_d;
    logic [9:0]    wipe_x_q, wipe_x_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          pend_valid_q, pend_valid_d;
    logic          pend_next_q, pend_next_d;
    logic          sel_q, sel_d;

    logic          ev_next, ev_prev, ev_both, ev_any;
    logic          take_next, take_prev;
    logic [10:0]   wipe_sum;

    function automatic logic [3:0] flag_inc(input logic [3:0] f);
        return (f == LAST_FLAG) ? 4'd0 : f + 4'd1;
    endfunction

    function automatic logic [3:0] flag_dec(input logic [3:0] f);
        return (f == 4'd0) ? LAST_FLAG : f - 4'd1;
    endfunction

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        nxt_d        = nxt_q;
        wipe_x_d     = wipe_x_q;
        dwell_d      = dwell_q;
        pend_valid_d = pend_valid_q;
        pend_next_d  = pend_next_q;
        sel_d        = (state_q == WIPE) && (pix_x < wipe_x_q);

        ev_both   = press[0] & press[1];
        ev_next   = press[0] & ~press[1];
        ev_prev   = press[1] & ~press[0];
        ev_any    = press[0] | press[1];
        // A fresh press overrides the latch; a cancelling pair also discards it.
        take_next = ev_next | (~ev_any & pend_valid_q & pend_next_q);
        take_prev = ev_prev | (~ev_any & pend_valid_q & ~pend_next_q);
        wipe_sum  = {1'b0, wipe_x_q} + STEP;

        if (frame_start) begin
            case (state_q)
                SHOW: begin
                    pend_valid_d = 1'b0;
                    if (take_next || take_prev) begin
                        nxt_d    = take_next ? flag_inc(cur_q) : flag_dec(cur_q);
                        wipe_x_d = '0;
                        dwell_d  = '0;
                        state_d  = WIPE;
                    end else if (auto_en && dwell_q == DWELL_LAST) begin
                        nxt_d    = flag_inc(cur_q);
                        wipe_x_d = '0;
                        dwell_d  = '0;
                        state_d  = WIPE;
                    end else if (auto_en) begin
                        dwell_d = dwell_q + 1'b1;
                    end else begin
                        dwell_d = '0;
                    end
                end
                WIPE: begin
                    if (ev_both) begin
                        pend_valid_d = 1'b0;
                    end else if (ev_next || ev_prev) begin
                        pend_valid_d = 1'b1;
                        pend_next_d  = ev_next;
                    end
                    if (wipe_sum >= 11'd640) begin
                        cur_d    = nxt_q;
                        wipe_x_d = '0;
                        dwell_d  = '0;
                        state_d  = SHOW;
                    end else begin
                        wipe_x_d = wipe_sum[9:0];
                    end
                end
                default: state_d = SHOW;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SHOW;
            cur_q        <= '0;
            nxt_q        <= '0;
            wipe_x_q     <= '0;
            dwell_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_next_q  <= 1'b0;
            sel_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            nxt_q        <= nxt_d;
            wipe_x_q     <= wipe_x_d;
            dwell_q      <= dwell_d;
            pend_valid_q <= pend_valid_d;
            pend_next_q  <= pend_next_d;
            sel_q        <= sel_d;
        end
    end

    assign cur_flag    = cur_q;
    assign next_flag   = nxt_q;
    assign sel_next    = sel_q;
    assign wipe_active = (state_q == WIPE);

endmodule

// File: tb/tb_flag_sequencer.sv
// Frame-level bench for flag_sequencer (3 flags, dwell 4, step 320, debounce 2):
// each frame pushes its expected outputs to a scoreboard and pops them after the edge.
module tb_flag_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic [9:0] pix_x = '0;
    logic       btn_next = 1'b0;
    logic       btn_prev = 1'b0;
    logic       auto_en = 1'b0;
    logic [3:0] cur_flag;
    logic [3:0] next_flag;
    logic       sel_next;
    logic       wipe_active;

    int n_checks = 0;
    int n_errors = 0;
    int frame_idx = 0;

    typedef struct {
        logic [3:0] cur;
        logic [3:0] nxt;
        logic       wa;
    } exp_t;

    exp_t sb[$];

    flag_sequencer #(
        .NUM_FLAGS      (3),
        .DWELL_FRAMES   (4),
        .WIPE_STEP      (320),
        .DEBOUNCE_FRAMES(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_start(frame_start),
        .pix_x      (pix_x),
        .btn_next   (btn_next),
        .btn_prev   (btn_prev),
        .auto_en    (auto_en),
        .cur_flag   (cur_flag),
        .next_flag  (next_flag),
        .sel_next   (sel_next),
        .wipe_active(wipe_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Hold buttons/auto_en for one frame, then issue one frame_start pulse.
    task automatic frame(input logic bn, input logic bp, input logic ae,
                         input logic [3:0] ec, input logic [3:0] en, input logic ew);
        exp_t e;
        @(negedge clk);
        btn_next = bn;
        btn_prev = bp;
        auto_en  = ae;
        repeat (4) @(negedge clk);
        e.cur = ec;
        e.nxt = en;
        e.wa  = ew;
        sb.push_back(e);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        frame_idx++;
        e = sb.pop_front();
        $display("frame %0d: bn=%0b bp=%0b ae=%0b cur=%0d next=%0d wipe=%0b", frame_idx,
                 bn, bp, ae, cur_flag, next_flag, wipe_active);
        check($sformatf("f%0d_cur", frame_idx), 32'(cur_flag), 32'(e.cur));
        check($sformatf("f%0d_next", frame_idx), 32'(next_flag), 32'(e.nxt));
        check($sformatf("f%0d_wipe", frame_idx), 32'(wipe_active), 32'(e.wa));
    endtask

    task automatic sel_check(input logic [9:0] px, input logic exp_v, input string tag);
        @(negedge clk);
        pix_x = px;
        @(negedge clk);
        $display("sel %s: pix_x=%0d sel_next=%0b", tag, px, sel_next);
        check(tag, 32'(sel_next), 32'(exp_v));
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_cur", 32'(cur_flag), 32'd0);
        check("rst_next", 32'(next_flag), 32'd0);
        check("rst_wipe", 32'(wipe_active), 32'd0);
        check("rst_sel", 32'(sel_next), 32'd0);
        rst_n = 1'b1;

        // Auto-advance: wipe starts on the 4th frame, lasts 3 frames.
        frame(0, 0, 1, 0, 0, 0);
        frame(0, 0, 1, 0, 0, 0);
        frame(0, 0, 1, 0, 0, 0);
        frame(0, 0, 1, 0, 1, 1);
        sel_check(10'd0, 1'b0, "sel_x0_px0");
        frame(0, 0, 1, 0, 1, 1);
        sel_check(10'd319, 1'b1, "sel_px319");
        sel_check(10'd320, 1'b0, "sel_px320");
        frame(0, 0, 1, 1, 1, 0);

        // Next press held 3 frames: exactly one wipe 1 -> 2.
        frame(0, 0, 0, 1, 1, 0);
        frame(1, 0, 0, 1, 1, 0);
        frame(1, 0, 0, 1, 1, 0);
        frame(1, 0, 0, 1, 2, 1);
        frame(0, 0, 0, 1, 2, 1);
        frame(0, 0, 0, 2, 2, 0);

        // Wrap forward 2 -> 0.
        frame(1, 0, 0, 2, 2, 0);
        frame(1, 0, 0, 2, 2, 0);
        frame(1, 0, 0, 2, 0, 1);
        frame(0, 0, 0, 2, 0, 1);
        frame(0, 0, 0, 0, 0, 0);

        // Wrap backward 0 -> 2.
        frame(0, 1, 0, 0, 0, 0);
        frame(0, 1, 0, 0, 0, 0);
        frame(0, 1, 0, 0, 2, 1);
        frame(0, 0, 0, 0, 2, 1);
        frame(0, 0, 0, 2, 2, 0);

        // One-frame glitch on next: rejected.
        frame(1, 0, 0, 2, 2, 0);
        frame(0, 0, 0, 2, 2, 0);
        frame(0, 0, 0, 2, 2, 0);
        frame(0, 0, 0, 2, 2, 0);

        // Simultaneous next+prev cancel; dwell keeps counting into an auto wipe.
        frame(1, 1, 1, 2, 2, 0);
        frame(1, 1, 1, 2, 2, 0);
        frame(1, 1, 1, 2, 2, 0);
        frame(0, 0, 1, 2, 0, 1);
        frame(0, 0, 0, 2, 0, 1);
        frame(0, 0, 0, 0, 0, 0);

        // Auto wipe 0 -> 1; prev then next during it; latched next acts after completion.
        frame(0, 0, 1, 0, 0, 0);
        frame(0, 0, 1, 0, 0, 0);
        frame(0, 1, 1, 0, 0, 0);
        frame(1, 1, 1, 0, 1, 1);
        frame(1, 0, 0, 0, 1, 1);
        frame(0, 0, 0, 1, 1, 0);
        frame(0, 0, 0, 1, 2, 1);
        frame(0, 0, 0, 1, 2, 1);
        frame(0, 0, 0, 2, 2, 0);

        // Auto wipe 2 -> 0, then asynchronous reset mid-wipe.
        frame(0, 0, 1, 2, 2, 0);
        frame(0, 0, 1, 2, 2, 0);
        frame(0, 0, 1, 2, 2, 0);
        frame(0, 0, 1, 2, 0, 1);
        frame(0, 0, 1, 2, 0, 1);
        sel_check(10'd319, 1'b1, "sel_pre_rst");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("async reset: cur=%0d next=%0d wipe=%0b sel=%0b", cur_flag, next_flag,
                 wipe_active, sel_next);
        check("arst_cur", 32'(cur_flag), 32'd0);
        check("arst_next", 32'(next_flag), 32'd0);
        check("arst_wipe", 32'(wipe_active), 32'd0);
        check("arst_sel", 32'(sel_next), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        frame(0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
